// File: rtl/pixel_stream_sink.sv
// pixel_stream_sink
// Accepts a raster pixel stream, writes each pixel to a framebuffer at
// y*H_RES+x, tracks framing against the parameter geometry, and keeps a
// per-frame rotating XOR checksum plus frame and framing-error counters.
module pixel_stream_sink #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int RGB_SIZE   = 24,
   parameter int ADDR_WIDTH = 19
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  stall,
   input  logic [7:0]            r,
   input  logic [7:0]            g,
   input  logic [7:0]            b,
   input  logic                  valid,
   input  logic                  first,
   input  logic                  last_x,
   input  logic                  last_y,
   output logic                  ready,
   output logic                  fb_we,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [RGB_SIZE-1:0]   fb_data,
   output logic                  frame_done,
   output logic [31:0]           checksum,
   output logic [15:0]           frame_count,
   output logic                  err_sof,
   output logic                  err_eol,
   output logic                  err_eof,
   output logic [15:0]           err_count
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic [0:0] {
      SYNC = 1'b0,
      RECV = 1'b1
   } state_t;

   // One checksum step: rotate left by one, then fold in the pixel.
   function automatic logic [31:0] csum_step(input logic [31:0] c, input logic [23:0] pix);
      return {c[30:0], c[31]} ^ {8'h00, pix};
   endfunction

   state_t                  state_r;
   logic [XW-1:0]           x_r;
   logic [YW-1:0]           y_r;
   logic [31:0]             csum_r;

   logic                    fb_we_r;
   logic [ADDR_WIDTH-1:0]   fb_addr_r;
   logic [RGB_SIZE-1:0]     fb_data_r;
   logic                    frame_done_r;
   logic [31:0]             checksum_r;
   logic [15:0]             frame_count_r;
   logic                    err_sof_r;
   logic                    err_eol_r;
   logic                    err_eof_r;
   logic [15:0]             err_count_r;

   logic                    accept_s;
   logic                    write_s;
   logic [XW-1:0]           px_s;
   logic [YW-1:0]           py_s;
   logic                    sof_s;
   logic                    eol_s;
   logic                    eof_s;
   logic                    last_x_pos_s;
   logic                    last_pos_s;
   logic [31:0]             base_s;
   logic [31:0]             csum_new_s;
   logic [ADDR_WIDTH-1:0]   addr_s;
   logic [1:0]              err_inc_s;
   logic [16:0]             err_sum_s;
   logic [15:0]             err_sat_s;

   assign ready    = en & ~stall & ~reset;
   assign accept_s = valid & ready;

   // Resolve the write position, frame-start restart and framing errors for this beat.
   always_comb begin
      write_s = 1'b0;
      px_s    = '0;
      py_s    = '0;
      sof_s   = 1'b0;
      base_s  = csum_r;
      if (accept_s) begin
         case (state_r)
            SYNC: begin
               if (first) begin
                  write_s = 1'b1;
                  base_s  = 32'h0000_0000;
               end else begin
                  write_s = 1'b0;
               end
            end
            RECV: begin
               write_s = 1'b1;
               if (first) begin
                  // A new frame start always resynchronises to the origin.
                  sof_s  = ~((x_r == '0) && (y_r == '0));
                  base_s = 32'h0000_0000;
               end else begin
                  px_s = x_r;
                  py_s = y_r;
               end
            end
            default: begin
               write_s = 1'b0;
            end
         endcase
      end else begin
         write_s = 1'b0;
      end

      last_x_pos_s = (px_s == XW'(H_RES - 1));
      last_pos_s   = last_x_pos_s && (py_s == YW'(V_RES - 1));
      eol_s        = write_s & (last_x != last_x_pos_s);
      eof_s        = write_s & (last_y != last_pos_s);
      csum_new_s   = csum_step(base_s, {b, g, r});
      addr_s       = ADDR_WIDTH'(py_s) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(px_s);
      err_inc_s    = {1'b0, sof_s} + {1'b0, eol_s} + {1'b0, eof_s};
      err_sum_s    = {1'b0, err_count_r} + {15'd0, err_inc_s};
      err_sat_s    = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
   end

   // Frame FSM, position counters, checksum and registered framebuffer/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= SYNC;
         x_r           <= '0;
         y_r           <= '0;
         csum_r        <= 32'h0000_0000;
         fb_we_r       <= 1'b0;
         fb_addr_r     <= '0;
         fb_data_r     <= '0;
         frame_done_r  <= 1'b0;
         checksum_r    <= 32'h0000_0000;
         frame_count_r <= 16'h0000;
         err_sof_r     <= 1'b0;
         err_eol_r     <= 1'b0;
         err_eof_r     <= 1'b0;
         err_count_r   <= 16'h0000;
      end else begin
         fb_we_r      <= write_s;
         frame_done_r <= 1'b0;
         err_sof_r    <= sof_s;
         err_eol_r    <= eol_s;
         err_eof_r    <= eof_s;
         if (write_s) begin
            fb_addr_r   <= addr_s;
            fb_data_r   <= RGB_SIZE'({b, g, r});
            err_count_r <= err_sat_s;
            csum_r      <= csum_new_s;
            if (last_pos_s) begin
               // Final pixel position closes the frame whatever last_y says.
               state_r       <= SYNC;
               x_r           <= '0;
               y_r           <= '0;
               checksum_r    <= csum_new_s;
               frame_count_r <= frame_count_r + 16'd1;
               frame_done_r  <= 1'b1;
            end else begin
               state_r <= RECV;
               if (last_x_pos_s) begin
                  x_r <= '0;
                  y_r <= py_s + YW'(1);
               end else begin
                  x_r <= px_s + XW'(1);
                  y_r <= py_s;
               end
            end
         end
      end
   end

   assign fb_we       = fb_we_r;
   assign fb_addr     = fb_addr_r;
   assign fb_data     = fb_data_r;
   assign frame_done  = frame_done_r;
   assign checksum    = checksum_r;
   assign frame_count = frame_count_r;
   assign err_sof     = err_sof_r;
   assign err_eol     = err_eol_r;
   assign err_eof     = err_eof_r;
   assign err_count   = err_count_r;

endmodule

// File: doc/pixel_stream_sink.md
PIXEL_STREAM_SINK -- requirements
Module: pixel_stream_sink

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter V_RES, default 480, lines per frame.
REQ-003 Parameter RGB_SIZE, default 24, pixel colour width as {b,g,r}, 8 bits each.
REQ-004 Parameter ADDR_WIDTH, default 19, framebuffer address width; SHALL satisfy 2^ADDR_WIDTH >= H_RES*V_RES.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  sink enable; 0 holds ready low.
REQ-008 stall  input  1  backpressure request; 1 holds ready low.
REQ-009 r, g, b  input  8 each  pixel colour from the stream source.
REQ-010 valid, first, last_x, last_y  input  1 each  stream beat valid, frame start, end of line, end of frame.
REQ-011 ready  output  1  sink can accept a beat this cycle.
REQ-012 fb_we  output  1  framebuffer write strobe.
REQ-013 fb_addr  output  ADDR_WIDTH  framebuffer write address, y*H_RES+x.
REQ-014 fb_data  output  RGB_SIZE  write data {b,g,r}.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-016 checksum  output  32  checksum of the last completed frame.
REQ-017 frame_count  output  16  completed frames, wraps at 16'hFFFF->0.
REQ-018 err_sof, err_eol, err_eof  output  1 each  one-cycle framing-error pulses.
REQ-019 err_count  output  16  total framing errors, saturates at 16'hFFFF.

Function
REQ-020 ready SHALL equal en & ~stall & ~reset, combinationally; a beat is accepted only when valid & ready.
REQ-021 The FSM SHALL have two states, SYNC and RECV.
REQ-022 In SYNC, accepted beats with first=0 SHALL be discarded without a write.
REQ-023 In SYNC, an accepted beat with first=1 SHALL be written at (0,0) and move the FSM to RECV.
REQ-024 In RECV, each accepted beat SHALL be written at the current (x,y); x SHALL increment, and at H_RES-1 wrap to 0 with y incremented.
REQ-025 Write latency SHALL be 1: fb_we, fb_addr and fb_data are registered, valid the cycle after acceptance; fb_we=0 otherwise.
REQ-026 In RECV, first=1 at a position other than (0,0) SHALL pulse err_sof and resynchronise: the beat is written at (0,0) and the running checksum restarts.
REQ-027 last_x not equal to (x==H_RES-1) on an accepted RECV beat SHALL pulse err_eol; the counters SHALL keep the parameter geometry.
REQ-028 last_y not equal to (x==H_RES-1 && y==V_RES-1) SHALL pulse err_eof; the counters SHALL keep the parameter geometry.
REQ-029 Errors detected on the same beat SHALL all pulse; err_count SHALL add the number of pulses asserted that cycle, saturating.
REQ-030 Running checksum: cleared on each frame start, then per accepted pixel csum <= {csum[30:0],csum[31]} ^ {8'h00,b,g,r}.
REQ-031 The beat at (H_RES-1,V_RES-1) SHALL complete the frame, regardless of last_y.
REQ-032 On frame completion, checksum SHALL load the final running value and frame_count SHALL increment, both in the same cycle as the frame_done pulse (aligned with that pixel's fb_we).
REQ-033 On frame completion, the FSM SHALL return to SYNC.
REQ-034 Error pulses SHALL be aligned with the fb_we of the offending beat.
REQ-035 A non-accepted cycle (valid=0 or ready=0) SHALL change no counter, checksum or state.

Reset
REQ-036 On reset: state=SYNC, x=y=0, running checksum=0.
REQ-037 On reset, all outputs SHALL be 0: fb_we, fb_addr, fb_data, frame_done, checksum, frame_count, err_*, err_count.
REQ-038 Reset mid-frame SHALL abandon the partial frame without a frame_done pulse; the next frame requires first=1.

Verification (H_RES=4, V_RES=2)
REQ-039 Clean frame, 8 beats of colour i (r=i), correct flags -> fb_addr 0..7; frame_done once, cycle after beat 7; frame_count=1; no errors.
REQ-040 Three beats with first=0, then a clean frame -> first three beats produce no fb_we; frame written at addr 0..7.
REQ-041 stall toggled every cycle, valid held high -> ready alternates; 8 writes; checksum identical to the REQ-039 run.
REQ-042 last_x missing at beat 3 -> one err_eol pulse; addresses unchanged; frame_done still after beat 7; err_count=1.
REQ-043 first asserted at beat 5 -> err_sof; that beat written at addr 0; frame completes 7 beats later.
REQ-044 reset asserted after beat 4, then a clean frame -> all outputs 0 after reset; frame_count=1 only after the new frame.
